// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - execute-stage ALU with single-cycle ops and iterative MULU/DIVU
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter bit MD_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_port,
  output logic [WIDTH-1:0] hi_port,
  output logic             negative,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state, state_n;
  logic [SW-1:0]    cnt;
  // MUL: {partial high, remaining multiplier}; DIV: {partial remainder, dividend/quotient}
  logic [2*WIDTH-1:0] prod;
  // multiplicand for MUL, divisor for DIV
  logic [WIDTH-1:0] opnd;

  logic             accept;
  logic             is_mul, is_div;
  logic             last;

  logic [WIDTH-1:0] sum, diff;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] s_res;
  logic             s_ovf;
  logic             s_ill;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  assign accept = in_valid && in_ready;
  assign is_mul = MD_EN && (op == 4'd11);
  assign is_div = MD_EN && (op == 4'd12);
  assign last   = (cnt == SW'(WIDTH - 1));
  assign sum    = portA + portB;
  assign diff   = portA - portB;
  assign shamt  = portB[SW-1:0];

  // one shift-add step: add multiplicand on multiplier LSB, then shift the pair right
  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, prod[WIDTH-1:1]};

  // one restoring-division step; a zero divisor naturally yields all-ones quotient and remainder = dividend
  assign div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd};
  assign div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};

  // single-cycle result, signed-overflow and illegal-op decode
  always_comb begin
    s_res = '0;
    s_ovf = 1'b0;
    s_ill = 1'b0;
    case (op)
      4'd0: begin
        s_res = sum;
        s_ovf = (portA[WIDTH-1] == portB[WIDTH-1]) && (sum[WIDTH-1] != portA[WIDTH-1]);
      end
      4'd1: begin
        s_res = diff;
        s_ovf = (portA[WIDTH-1] != portB[WIDTH-1]) && (diff[WIDTH-1] != portA[WIDTH-1]);
      end
      4'd2:  s_res = portA & portB;
      4'd3:  s_res = portA | portB;
      4'd4:  s_res = portA ^ portB;
      4'd5:  s_res = ~(portA | portB);
      4'd6:  s_res = portA << shamt;
      4'd7:  s_res = portA >> shamt;
      4'd8:  s_res = WIDTH'($signed(portA) >>> shamt);
      4'd9:  s_res = {{(WIDTH-1){1'b0}}, ($signed(portA) < $signed(portB))};
      4'd10: s_res = {{(WIDTH-1){1'b0}}, (portA < portB)};
      4'd11, 4'd12: s_ill = !MD_EN;
      default: s_ill = 1'b1;
    endcase
  end

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  // next state and input handshake
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && (!out_valid || out_ready)) begin
          if (is_mul)      state_n = S_MUL;
          else if (is_div) state_n = S_DIV;
        end
      end
      S_MUL, S_DIV: if (last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // operand latching, iteration and result/flag registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt         <= '0;
      prod        <= '0;
      opnd        <= '0;
      out_valid   <= 1'b0;
      output_port <= '0;
      hi_port     <= '0;
      negative    <= 1'b0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul || is_div) begin
              cnt  <= '0;
              opnd <= is_mul ? portA : portB;
              prod <= {{WIDTH{1'b0}}, (is_mul ? portB : portA)};
            end else begin
              out_valid   <= 1'b1;
              output_port <= s_res;
              hi_port     <= '0;
              negative    <= s_res[WIDTH-1];
              overflow    <= s_ovf;
              zero        <= (s_res == '0);
              illegal     <= s_ill;
            end
          end
        end
        S_MUL: begin
          prod <= mul_next;
          cnt  <= cnt + 1'b1;
          if (last) begin
            out_valid   <= 1'b1;
            output_port <= mul_next[WIDTH-1:0];
            hi_port     <= mul_next[2*WIDTH-1:WIDTH];
            negative    <= mul_next[WIDTH-1];
            overflow    <= 1'b0;
            zero        <= (mul_next[WIDTH-1:0] == '0);
            illegal     <= 1'b0;
          end
        end
        S_DIV: begin
          prod <= div_next;
          cnt  <= cnt + 1'b1;
          if (last) begin
            out_valid   <= 1'b1;
            output_port <= div_next[WIDTH-1:0];
            hi_port     <= div_next[2*WIDTH-1:WIDTH];
            negative    <= div_next[WIDTH-1];
            overflow    <= (opnd == '0);
            zero        <= (div_next[WIDTH-1:0] == '0);
            illegal     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
